mu_fifo_burst_reader: RTL and testbench

Read-side consumer for the dual-clock FIFO. Runs in the FIFO read clock domain, watches the read-side fill count and drains the FIFO in fixed-length bursts toward a burst-oriented sink such as the SDRAM frame writer. Each burst carries a frame-relative word address. Before any data moves, a request/acknowledge handshake with the sink is required. A flush input drains a final partial burst at end of frame.

---
 rtl/mu_fifo_burst_reader_if.sv | 40 ++++
 rtl/mu_fifo_burst_reader.sv | 120 ++++++++++++
 tb/tb_mu_fifo_burst_reader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mu_fifo_burst_reader_if.sv
// Bundle between the burst reader, its source FIFO read port and the burst sink.
// master is the reader side, slave is the FIFO/sink side.
interface mu_fifo_burst_reader_if #(
    parameter int DW        = 16,
    parameter int AW        = 4,
    parameter int BURST_LEN = 8,
    parameter int ADDR_W    = 20
);
    localparam int LW = $clog2(BURST_LEN + 1);

    logic [DW-1:0]     fifo_dout;
    logic              fifo_valid;
    logic              fifo_ready;
    logic [AW:0]       fifo_used;
    logic              flush;
    logic              frame_start;
    logic              burst_req;
    logic [ADDR_W-1:0] burst_addr;
    logic [LW-1:0]     burst_len;
    logic              burst_ack;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;

    modport master (
        input  fifo_dout, fifo_valid, fifo_used,
        input  flush, frame_start, burst_ack, out_ready,
        output fifo_ready, burst_req, burst_addr, burst_len,
        output out_data, out_valid, out_last, busy
    );

    modport slave (
        output fifo_dout, fifo_valid, fifo_used,
        output flush, frame_start, burst_ack, out_ready,
        input  fifo_ready, burst_req, burst_addr, burst_len,
        input  out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/mu_fifo_burst_reader.sv
// Drains the read side of the dual-clock FIFO in fixed bursts toward a
// burst sink, with request/ack, end-of-frame flush and frame address wrap.
module mu_fifo_burst_reader #(
    parameter int DW          = 16,
    parameter int AW          = 4,
    parameter int BURST_LEN   = 8,
    parameter int ADDR_W      = 20,
    parameter int FRAME_WORDS = 19200
) (
    input  logic                  clk,
    input  logic                  nreset,
    mu_fifo_burst_reader_if.master bus
);
    localparam int LW = $clog2(BURST_LEN + 1);

    localparam logic [AW:0]     BL_USED = (AW + 1)'(BURST_LEN);
    localparam logic [LW-1:0]   BL_LEN  = LW'(BURST_LEN);
    localparam logic [ADDR_W:0] FW      = (ADDR_W + 1)'(FRAME_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_STREAM,
        S_SETTLE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LW-1:0]     r_len;
    logic [LW-1:0]     r_rem;
    logic              r_flush_pend;
    logic              r_frame_pend;
    logic              r_req;
    logic              r_busy;

    logic              w_stream;
    logic              w_beat;
    logic              w_last;
    logic [ADDR_W:0]   w_sum;
    logic [ADDR_W-1:0] w_next_addr;

    assign w_stream = (r_state == S_STREAM);
    assign w_beat   = w_stream & bus.out_ready & bus.fifo_valid;
    assign w_last   = (r_rem == LW'(1));

    // Sum is one bit wider so the wrap compare sees the true total.
    assign w_sum       = {1'b0, r_addr} + (ADDR_W + 1)'(r_len);
    assign w_next_addr = ADDR_W'((w_sum >= FW) ? (w_sum - FW) : w_sum);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_len        <= '0;
            r_rem        <= '0;
            r_flush_pend <= 1'b0;
            r_frame_pend <= 1'b0;
            r_req        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_flush_pend <= r_flush_pend | bus.flush;
            r_frame_pend <= r_frame_pend | bus.frame_start;
            unique case (r_state)
                S_IDLE: begin
                    if (r_frame_pend) begin
                        r_addr       <= '0;
                        r_frame_pend <= bus.frame_start;
                    end else if (bus.fifo_used >= BL_USED) begin
                        // A pending flush waits until the full burst is out.
                        r_len   <= BL_LEN;
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (r_flush_pend && bus.fifo_used != '0) begin
                        r_len        <= LW'(bus.fifo_used);
                        r_flush_pend <= bus.flush;
                        r_state      <= S_REQ;
                        r_req        <= 1'b1;
                        r_busy       <= 1'b1;
                    end else if (r_flush_pend) begin
                        r_flush_pend <= bus.flush;
                    end
                end
                S_REQ: begin
                    if (bus.burst_ack) begin
                        r_req   <= 1'b0;
                        r_rem   <= r_len;
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_beat) begin
                        r_rem <= r_rem - LW'(1);
                        if (w_last) begin
                            r_addr  <= w_next_addr;
                            r_state <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    // fifo_used still shows the last pop here; wait it out.
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fifo_ready = w_beat;
    assign bus.out_valid  = w_stream & bus.fifo_valid;
    assign bus.out_last   = w_stream & w_last;
    assign bus.out_data   = w_stream ? bus.fifo_dout : '0;
    assign bus.burst_req  = r_req;
    assign bus.burst_addr = r_addr;
    assign bus.burst_len  = r_len;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_mu_fifo_burst_reader.sv
// Directed scoreboard bench for mu_fifo_burst_reader with a small FIFO model
// whose fill count lags pops by one cycle, as the real read side does.
module tb_mu_fifo_burst_reader;
    localparam int DW     = 16;
    localparam int AW     = 4;
    localparam int BL     = 8;
    localparam int ADDR_W = 20;
    localparam int FW     = 16;

    typedef struct {
        int addr;
        int len;
    } burst_t;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    mu_fifo_burst_reader_if #(
        .DW(DW), .AW(AW), .BURST_LEN(BL), .ADDR_W(ADDR_W)
    ) bus ();

    mu_fifo_burst_reader #(
        .DW(DW), .AW(AW), .BURST_LEN(BL), .ADDR_W(ADDR_W), .FRAME_WORDS(FW)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .bus(bus.master)
    );

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_data[$];
    burst_t        exp_b[$];
    int            exp_left;
    int            beats;
    int            n_tests;
    int            n_fail;
    logic          gap;
    logic          rdy_s;
    logic [DW-1:0] wctr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        bus.fifo_valid = (fq.size() != 0) && !gap;
        bus.fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(wctr);
            exp_data.push_back(wctr);
            wctr++;
        end
        refresh();
    endtask

    task automatic exp_burst(input int a, input int l);
        burst_t b;
        b.addr = a;
        b.len  = l;
        exp_b.push_back(b);
    endtask

    task automatic monitor();
        logic [DW-1:0] e;
        burst_t b;
        rdy_s = bus.fifo_ready;
        chk("pop_eq_beat", 32'(bus.fifo_ready),
            32'(bus.out_valid & bus.out_ready));
        if (bus.out_valid && bus.out_ready) begin
            beats++;
            if (exp_data.size() == 0) begin
                chk("beat_unexpected", 32'(1), 32'(0));
            end else begin
                e = exp_data.pop_front();
                chk("beat_data", 32'(bus.out_data), 32'(e));
            end
            chk("beat_last", 32'(bus.out_last), 32'(exp_left == 1));
            if (exp_left > 0) exp_left--;
        end
        if (bus.burst_req) begin
            chk("req_busy", 32'(bus.busy), 32'(1));
            if (exp_b.size() == 0) begin
                chk("unexp_req", 32'(1), 32'(0));
            end else begin
                b = exp_b.pop_front();
                chk("req_addr", 32'(bus.burst_addr), 32'(b.addr));
                chk("req_len", 32'(bus.burst_len), 32'(b.len));
                exp_left = b.len;
            end
            bus.burst_ack = 1'b1;
        end
    endtask

    task automatic step();
        int used_n;
        @(negedge clk);
        refresh();
        #1;
        monitor();
        @(posedge clk);
        #1;
        bus.burst_ack = 1'b0;
        used_n = fq.size();
        if (rdy_s && fq.size() != 0) void'(fq.pop_front());
        bus.fifo_used = (AW + 1)'(used_n);
        refresh();
        bus.flush       = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_done(input string tag, input int tmo);
        int i;
        i = 0;
        step();
        while ((exp_b.size() != 0 || exp_left != 0 || bus.busy) && i < tmo) begin
            step();
            i++;
        end
        chk({"done_", tag}, 32'(i < tmo), 32'(1));
    endtask

    task automatic wait_ack(input string tag, input int tmo);
        int i;
        i = 0;
        while (exp_b.size() != 0 && i < tmo) begin
            step();
            i++;
        end
        chk({"ack_", tag}, 32'(i < tmo), 32'(1));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_fifo_ready"}, 32'(bus.fifo_ready), 32'(0));
        chk({tag, "_burst_req"}, 32'(bus.burst_req), 32'(0));
        chk({tag, "_burst_addr"}, 32'(bus.burst_addr), 32'(0));
        chk({tag, "_burst_len"}, 32'(bus.burst_len), 32'(0));
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(0));
        chk({tag, "_out_last"}, 32'(bus.out_last), 32'(0));
        chk({tag, "_out_data"}, 32'(bus.out_data), 32'(0));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int i;
        n_tests = 0;
        n_fail = 0;
        exp_left = 0;
        beats = 0;
        gap = 1'b0;
        rdy_s = 1'b0;
        wctr = 16'h1000;
        bus.fifo_used = '0;
        bus.flush = 1'b0;
        bus.frame_start = 1'b0;
        bus.burst_ack = 1'b0;
        bus.out_ready = 1'b1;
        refresh();

        #12;
        chk_zero("reset");
        nreset = 1'b1;

        // Start-up burst, then full burst at 8 plus a flushed remainder.
        b0 = beats;
        push(8);
        exp_burst(0, 8);
        wait_done("startup", 60);
        chk("startup_beats", 32'(beats - b0), 32'(8));

        b0 = beats;
        push(13);
        bus.flush = 1'b1;
        exp_burst(8, 8);
        exp_burst(0, 5);
        wait_done("flush13", 100);
        chk("flush13_beats", 32'(beats - b0), 32'(13));
        idle(20);
        chk("flush13_drained", 32'(fq.size()), 32'(0));

        // Flush with nothing buffered must not linger.
        bus.flush = 1'b1;
        idle(5);
        push(3);
        idle(15);
        chk("empty_flush_held", 32'(fq.size()), 32'(3));
        b0 = beats;
        bus.flush = 1'b1;
        exp_burst(5, 3);
        wait_done("flush3", 60);
        chk("flush3_beats", 32'(beats - b0), 32'(3));

        // Frame restart requested mid-stream at addr 8.
        push(3);
        bus.flush = 1'b1;
        exp_burst(8, 3);
        wait_ack("frame", 30);
        bus.frame_start = 1'b1;
        wait_done("frame", 60);

        // Backpressure and a valid gap, starting at the restarted address.
        b0 = beats;
        push(8);
        exp_burst(0, 8);
        wait_ack("bp", 30);
        for (int k = 0; k < 4; k++) begin
            bus.out_ready = (k % 2 == 0);
            step();
        end
        chk("bp_mid_beats", 32'(beats - b0), 32'(2));
        bus.out_ready = 1'b1;
        gap = 1'b1;
        idle(3);
        chk("bp_gap_beats", 32'(beats - b0), 32'(2));
        gap = 1'b0;
        wait_done("bp", 60);
        chk("bp_beats", 32'(beats - b0), 32'(8));

        // Reset after three beats, then drain the remainder via flush.
        b0 = beats;
        push(8);
        exp_burst(8, 8);
        i = 0;
        while (beats - b0 < 3 && i < 60) begin
            step();
            i++;
        end
        chk("rst_three_beats", 32'(beats - b0), 32'(3));
        nreset = 1'b0;
        exp_left = 0;
        #1;
        chk_zero("midrst");
        idle(2);
        chk("midrst_no_pops", 32'(fq.size()), 32'(5));
        nreset = 1'b1;
        b0 = beats;
        bus.flush = 1'b1;
        exp_burst(0, 5);
        wait_done("postrst", 60);
        chk("postrst_beats", 32'(beats - b0), 32'(5));
        idle(10);
        chk("end_fifo_empty", 32'(fq.size()), 32'(0));
        chk("end_data_left", 32'(exp_data.size()), 32'(0));
        chk("end_bursts_left", 32'(exp_b.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
